// File: rtl/dma_xfer_ctl_if.sv
// Configuration, handshake and counter-observation bundle for dma_xfer_ctl.
// Signal names match the block's port list; clk/rst_n stay outside the bundle.
interface dma_xfer_ctl_if;
  logic       cfg_we;
  logic [1:0] cfg_sel;
  logic [7:0] cfg_data;
  logic       start;
  logic       abort;
  logic       dreq;
  logic       dack;
  logic       busy;
  logic       tc;
  logic [7:0] ac;
  logic [7:0] wc;

  modport slave (
    input  cfg_we, cfg_sel, cfg_data, start, abort, dreq,
    output dack, busy, tc, ac, wc
  );

  modport master (
    output cfg_we, cfg_sel, cfg_data, start, abort, dreq,
    input  dack, busy, tc, ac, wc
  );
endinterface

// File: rtl/dma_xfer_ctl.sv
// Single-channel DMA transfer sequencer: WAIT for dreq, strobe dack, update
// address/word counters, signal terminal count, optionally auto-reload.
module dma_xfer_ctl (
  input  logic           clk,
  input  logic           rst_n,
  dma_xfer_ctl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, WAIT, XFER, UPD} state_e;

  state_e     state_q, state_d;
  logic [7:0] acr_q, wcr_q;
  logic [1:0] mode_q;
  logic       auto_q;
  logic [7:0] ac_q, ac_d, wc_q, wc_d;
  logic       dack_q, dack_d, busy_q, busy_d, tc_q, tc_d;

  logic       cfg_ok;
  logic [7:0] ac_inc, wc_step, wc_init;
  logic       term;

  assign cfg_ok  = bus.cfg_we & ~busy_q;
  assign ac_inc  = ac_q + 8'd1;
  assign wc_step = (mode_q == 2'b00) ? (wc_q - 8'd1) : (wc_q + 8'd1);
  assign wc_init = (mode_q == 2'b01) ? 8'd0 : wcr_q;

  // Terminal test looks at the values this UPD cycle is about to write.
  always_comb begin
    term = 1'b0;
    case (mode_q)
      2'b00:   term = (wc_step == 8'd0);
      2'b01:   term = (wc_step == wcr_q);
      2'b10:   term = (ac_inc == wcr_q);
      default: term = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acr_q   <= 8'd0;
      wcr_q   <= 8'd0;
      mode_q  <= 2'b00;
      auto_q  <= 1'b0;
      ac_q    <= 8'd0;
      wc_q    <= 8'd0;
      dack_q  <= 1'b0;
      busy_q  <= 1'b0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ac_q    <= ac_d;
      wc_q    <= wc_d;
      dack_q  <= dack_d;
      busy_q  <= busy_d;
      tc_q    <= tc_d;
      if (cfg_ok) begin
        case (bus.cfg_sel)
          2'b00:   acr_q <= bus.cfg_data;
          2'b01:   wcr_q <= bus.cfg_data;
          2'b10:   {auto_q, mode_q} <= bus.cfg_data[2:0];
          default: ;
        endcase
      end
    end
  end

  // Abort wins over everything; start outside IDLE falls through unused.
  always_comb begin
    state_d = state_q;
    if (bus.abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (bus.start) state_d = WAIT;
        WAIT:    if (bus.dreq)  state_d = XFER;
        XFER:    state_d = UPD;
        UPD:     state_d = (term && !auto_q) ? IDLE : WAIT;
        default: state_d = IDLE;
      endcase
    end
  end

  // Registered outputs are derived from the next state so dack/busy/tc
  // leave flops with no input-to-output combinational path.
  always_comb begin
    ac_d   = ac_q;
    wc_d   = wc_q;
    tc_d   = 1'b0;
    dack_d = (state_d == XFER);
    busy_d = (state_d != IDLE);
    if (!bus.abort) begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            ac_d = acr_q;
            wc_d = wc_init;
          end
        end
        UPD: begin
          tc_d = term;
          if (term && auto_q) begin
            ac_d = acr_q;
            wc_d = wc_init;
          end else begin
            ac_d = ac_inc;
            wc_d = wc_step;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.dack = dack_q;
  assign bus.busy = busy_q;
  assign bus.tc   = tc_q;
  assign bus.ac   = ac_q;
  assign bus.wc   = wc_q;

endmodule

// File: doc/dma_xfer_ctl.md
DMA_XFER_CTL -- requirements
Module: dma_xfer_ctl

Interface
REQ-001 SHALL declare the following ports:
- clk  in  1  rising-edge clock; sole clock of the block
- rst_n  in  1  asynchronous, active-low reset
- cfg_we  in  1  configuration write strobe
- cfg_sel  in  2  register select: 00 acr, 01 wcr, 10 mode, 11 reserved (write ignored)
- cfg_data  in  8  write data; mode uses bits [2:0] = {autoinit, mode[1:0]}
- start  in  1  one-cycle pulse; begins a transfer sequence
- abort  in  1  one-cycle pulse; terminates any sequence
- dreq  in  1  level; requester ready for one transfer
- dack  out  1  one-cycle transfer acknowledge / strobe
- busy  out  1  high in every state except IDLE
- tc  out  1  one-cycle terminal-count pulse
- ac  out  8  current address counter
- wc  out  8  current word counter

Function
REQ-002 Registers acr, wcr, mode, autoinit SHALL be written on the clock edge where cfg_we=1 and busy=0; writes while busy=1 SHALL be ignored.
REQ-003 States SHALL be IDLE, WAIT, XFER, UPD.
REQ-004 IDLE: start=1 and abort=0 -> WAIT; load ac<=acr; wc<=wcr for modes 00/10/11, wc<=0 for mode 01.
REQ-005 WAIT: dreq=1 -> XFER; dreq=0 -> remain in WAIT.
REQ-006 XFER: dack=1 for exactly this one cycle; unconditional -> UPD.
REQ-007 UPD: ac<=ac+1 (mod 256); wc<=wc-1 (mode 00) or wc+1 (modes 01/10/11), mod 256.
REQ-008 The terminal condition SHALL be evaluated on the post-update values:
- mode 00: wc==0
- mode 01: wc==wcr
- mode 10: ac==wcr (wcr serves as the address limit)
- mode 11: never
REQ-009 UPD, terminal and autoinit=1: tc=1 on the following cycle; reload ac/wc per REQ-004; -> WAIT.
REQ-010 UPD, terminal and autoinit=0: tc=1 on the following cycle; -> IDLE.
REQ-011 UPD, not terminal: -> WAIT.
REQ-012 tc SHALL be registered, high for exactly one cycle, and coincident with the first cycle of the next state.
REQ-013 Wrap-around: mode 00 started with wcr=0 and mode 01 started with wcr=0 SHALL each perform 256 transfers before tc.
REQ-014 Mode 10 started with acr==wcr SHALL perform 256 transfers before tc.
REQ-015 abort=1 in any state:
- next state IDLE
- no counter update, no tc
- abort takes priority over start and dreq
- abort during XFER: dack is still completed that cycle, UPD is skipped
REQ-016 start while busy=1 SHALL be ignored.
REQ-017 ac and wc SHALL hold their values in IDLE after completion or abort, and SHALL be visible continuously.
REQ-018 dack, busy and tc SHALL be driven directly from registers with no combinational path from any input.
REQ-019 Per-transfer latency SHALL be: dreq sampled high in WAIT -> dack on the next cycle -> counters updated one cycle later; minimum 3 cycles per transfer.

Reset
REQ-020 rst_n=0 SHALL asynchronously force state=IDLE; dack, busy, tc = 0; ac, wc, acr, wcr = 0x00; mode = 00; autoinit = 0.
REQ-021 Reset asserted mid-sequence SHALL abandon the sequence with no tc.
REQ-022 After rst_n deasserts, the first start SHALL be accepted on the first rising edge.

Verification
REQ-023 Mode 00: acr=0x10, wcr=3, dreq held high, start -> 3 dack pulses; ac=0x13, wc=0; one tc; busy low after tc.
REQ-024 Mode 01: wcr=2, autoinit=1, dreq high -> tc after every 2nd dack; wc reloads to 0; busy stays high until abort.
REQ-025 Mode 10: acr=0xFE, wcr=0x01 -> 3 transfers (ac 0xFF, 0x00, 0x01); tc on the third.
REQ-026 Mode 00 with wcr=0 -> exactly 256 dack pulses, then tc; wc=0.
REQ-027 dreq toggled low between transfers -> block remains in WAIT with no dack; abort asserted during XFER -> dack completes, counters unchanged, no tc, busy low next cycle.
REQ-028 cfg_we asserted while busy -> acr, wcr and mode unchanged; reset asserted mid-transfer -> all outputs immediately 0.
